iq_accumulator: RTL
===================

# iq_accumulator

- Integrates a windowed burst of signed baseband I/Q ADC samples into one pair of 32-bit sums per readout shot.
- Sits directly upstream of the normalizer. Its packed `{I,Q}` result drives the normalizer's `accumulated_input`, and its done strobe drives `stb_start`.
- Each shot is started by a readout trigger, skips a programmable settling interval, accumulates a programmable number of valid samples, then presents the sums with a one-cycle strobe.

## Interface

Parameters
- `SAMPLE_WIDTH`, 16: signed width of each incoming I and Q sample.
- `ACC_WIDTH`, 32: signed width of each accumulated sum. Must be 32 to match the normalizer's input slicing.
- `CNT_WIDTH`, 16: width of the skip and window length counters.

Ports (clock and reset first)
- `clk` input 1: sole clock. All logic on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `trig` input 1: readout start pulse. Sampled only in IDLE.
- `skip_len` input CNT_WIDTH: number of valid samples discarded after the trigger. Latched on an accepted `trig`.
- `win_len` input CNT_WIDTH: number of valid samples summed. Latched on an accepted `trig`.
- `sample_valid` input 1: qualifies `sample_i` and `sample_q` this cycle.
- `sample_i` input SAMPLE_WIDTH: signed in-phase sample.
- `sample_q` input SAMPLE_WIDTH: signed quadrature sample.
- `accumulated_output` output 2*ACC_WIDTH: `{sumI, sumQ}`, with I in the upper half. Registered, and held until the next shot completes.
- `stb_done` output 1: one-cycle pulse when `accumulated_output` updates.
- `busy` output 1: high in every state except IDLE.
- `sat_flag` output 1: set if either lane saturated during the last completed shot.

## Operation

- FSM states: IDLE, SKIP, ACCUM, DONE.
- IDLE:
  - On `trig`=1, latch `skip_len` and `win_len` and clear both lane accumulators and the internal saturation bit.
  - Go to SKIP if `skip_len`≠0, else ACCUM.
- SKIP:
  - Each cycle with `sample_valid`=1 increments the skip counter.
  - Leave for ACCUM in the cycle the counter reaches `skip_len`. That sample is discarded.
- ACCUM:
  - Each valid sample is sign-extended to ACC_WIDTH and added to its lane.
  - The cycle that accepts the `win_len`-th sample transitions to DONE.
  - If `win_len`=0, ACCUM transitions to DONE immediately, with zero sums.
- DONE:
  - One cycle long.
  - Register the lane sums into `accumulated_output` and the saturation bit into `sat_flag`.
  - Assert `stb_done`, then return to IDLE.
- `trig` outside IDLE is ignored; it is neither queued nor allowed to restart the shot.
- `sample_valid` is ignored in IDLE and DONE.
- `trig` asserted in the same cycle as the DONE→IDLE transition is ignored. A new shot needs `trig` while the FSM is already in IDLE.
- Arithmetic is two's-complement. Each lane adds independently, with no rounding.

## Timing

- Reset values: `accumulated_output`=0, `stb_done`=0, `busy`=0, `sat_flag`=0, FSM in IDLE, and all counters and accumulators 0.
- Latency:
  - `busy` rises in the cycle after `trig` is accepted.
  - `stb_done` is high exactly one cycle after the clock edge that accepts the last window sample.
  - With continuous `sample_valid`, `stb_done` rises skip_len+win_len+2 cycles after the `trig` cycle.
- `accumulated_output` and `sat_flag` change only on the `stb_done` cycle and are valid throughout it. The normalizer may sample them any time after.
- Reset asserted mid-shot aborts immediately:
  - outputs return to reset values;
  - no `stb_done` is produced;
  - the post-reset FSM is IDLE.
- A lane sum of exactly the extreme value (max positive, or min negative) is not counted as saturation.

## Configuration

- `IQ_ACC_SAT_EN` defined:
  - Each lane add clamps to +2^(ACC_WIDTH-1)-1 or −2^(ACC_WIDTH-1) on overflow.
  - Once clamped, the lane stays at that rail until the shot ends.
  - `sat_flag` reports the event.
- `IQ_ACC_SAT_EN` undefined:
  - Lane adds wrap modulo 2^ACC_WIDTH.
  - `sat_flag` is tied to 0.

## Structure

- Package `iq_acc_pkg` holds:
  - the FSM state enum `iq_acc_state_t` (IDLE, SKIP, ACCUM, DONE);
  - default width constants `IQ_SAMPLE_W`=16, `IQ_ACC_W`=32, `IQ_CNT_W`=16.
- Sub-module `iq_acc_lane` is instantiated twice, once for I and once for Q:
  - inputs: clear, add enable, sample;
  - outputs: sum, sat;
  - the saturation logic under `IQ_ACC_SAT_EN` lives only here.
- The top level owns the FSM, the counters, the input latching and the output registers.

## Test plan

- Reset: assert `rst_n`=0 mid-stream → all outputs 0, `busy`=0, and no `stb_done` for 100 cycles after release with no `trig`.
- Basic shot: skip_len=4, win_len=8, continuous valid, I=+100, Q=−50 → `stb_done` 14 cycles after `trig`, output `{32'd800, −32'd400}`, `sat_flag`=0.
- Gapped valid: skip_len=2, win_len=5, valid every other cycle, I ramp 1..7, Q=3 → skips 1 and 2, sums I=3+4+5+6+7=25 and Q=15. The strobe fires one cycle after the 7th valid sample.
- Edge lengths:
  - skip_len=0, win_len=0 → `stb_done` 2 cycles after `trig`, output 0.
  - A second `trig` pulsed while `busy` is high → ignored, and only one strobe results.
- Overflow, win_len=65535 with I=+32767 (sum 0x7FFE8001, no overflow):
  - with I=+32767 and ACC_WIDTH forced to 24, `IQ_ACC_SAT_EN` defined → I=+8388607 and `sat_flag`=1;
  - macro undefined → wrapped value and `sat_flag`=0.
- Abort: drop `rst_n` during ACCUM, release, `trig` again with skip 0 and win 3, I=Q=1 → no strobe from the aborted shot, and the new result is `{3,3}`.

Source files
------------

// File: rtl/iq_acc_pkg.sv
// Shared types and default widths for the I/Q burst accumulator.
// Optional feature macro used by this block: IQ_ACC_SAT_EN (per-lane saturation).
package iq_acc_pkg;

  localparam int IQ_SAMPLE_W = 16;
  localparam int IQ_ACC_W    = 32;
  localparam int IQ_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACCUM,
    DONE
  } iq_acc_state_t;

endpackage

// File: rtl/iq_acc_lane.sv
// One accumulator lane (I or Q): sign-extends each sample and adds it to a running sum.
// With IQ_ACC_SAT_EN defined the sum clamps to the signed rails on overflow and stays
// there until the next clear; otherwise it wraps and sat is held low.
module iq_acc_lane
  import iq_acc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = IQ_SAMPLE_W,
  parameter int ACC_WIDTH    = IQ_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    add_en,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    sat
);

  logic [ACC_WIDTH-1:0] ext;

  // Sign-extend the incoming sample to the accumulator width
  always_comb begin
    ext = {{(ACC_WIDTH-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
  end

`ifdef IQ_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wide;

  // One guard bit: overflow shows up as the top two bits disagreeing
  always_comb begin
    wide = {sum[ACC_WIDTH-1], sum} + {ext[ACC_WIDTH-1], ext};
  end

  // Saturating accumulate; a clamped lane ignores further samples so it holds its rail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (add_en && !sat) begin
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
        sum <= wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX;
        sat <= 1'b1;
      end else begin
        sum <= wide[ACC_WIDTH-1:0];
      end
    end
  end
`else
  // Wrapping accumulate, modulo 2^ACC_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + ext;
    end
  end

  assign sat = 1'b0;
`endif

endmodule

// File: rtl/iq_accumulator.sv
// Windowed I/Q burst integrator: after a trigger, discards skip_len valid samples, sums the
// next win_len valid samples per lane, then presents {sumI, sumQ} with a one-cycle strobe.
// Optional feature macro: IQ_ACC_SAT_EN (lane saturation and sat_flag reporting).
module iq_accumulator
  import iq_acc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = IQ_SAMPLE_W,
  parameter int ACC_WIDTH    = IQ_ACC_W,
  parameter int CNT_WIDTH    = IQ_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trig,
  input  logic [CNT_WIDTH-1:0]    skip_len,
  input  logic [CNT_WIDTH-1:0]    win_len,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_q,
  output logic [2*ACC_WIDTH-1:0]  accumulated_output,
  output logic                    stb_done,
  output logic                    busy,
  output logic                    sat_flag
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  iq_acc_state_t state;
  iq_acc_state_t next_state;

  logic [CNT_WIDTH-1:0] skip_q;
  logic [CNT_WIDTH-1:0] win_q;
  logic [CNT_WIDTH-1:0] skip_cnt;
  logic [CNT_WIDTH-1:0] win_cnt;

  logic                 accept;
  logic                 add_en;
  logic [ACC_WIDTH-1:0] sum_i;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 sat_i;
  logic                 sat_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control strobes; an empty window never occupies an ACCUM cycle,
  // which keeps strobe latency at skip_len+win_len+2 even for win_len=0
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    add_en     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          accept = 1'b1;
          if (skip_len != '0) begin
            next_state = SKIP;
          end else if (win_len == '0) begin
            next_state = DONE;
          end else begin
            next_state = ACCUM;
          end
        end
      end
      SKIP: begin
        if (sample_valid && (skip_cnt + CNT_ONE == skip_q)) begin
          next_state = (win_q == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (win_q == '0) begin
          next_state = DONE;
        end else if (sample_valid) begin
          add_en = 1'b1;
          if (win_cnt + CNT_ONE == win_q) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Length latching on an accepted trigger, plus the skip and window counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q   <= '0;
      win_q    <= '0;
      skip_cnt <= '0;
      win_cnt  <= '0;
    end else if (accept) begin
      skip_q   <= skip_len;
      win_q    <= win_len;
      skip_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      if (state == SKIP && sample_valid) begin
        skip_cnt <= skip_cnt + CNT_ONE;
      end
      if (add_en) begin
        win_cnt <= win_cnt + CNT_ONE;
      end
    end
  end

  iq_acc_lane #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) lane_i (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .add_en(add_en),
    .sample(sample_i),
    .sum   (sum_i),
    .sat   (sat_i)
  );

  iq_acc_lane #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) lane_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .add_en(add_en),
    .sample(sample_q),
    .sum   (sum_q),
    .sat   (sat_q)
  );

  // Result registers load as DONE is left, so the strobe and new result appear together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accumulated_output <= '0;
      sat_flag           <= 1'b0;
      stb_done           <= 1'b0;
    end else begin
      stb_done <= (state == DONE);
      if (state == DONE) begin
        accumulated_output <= {sum_i, sum_q};
        sat_flag           <= sat_i | sat_q;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
